// File: rtl/counter_updown_mod.sv
// rtl/counter_updown_mod.sv - up/down modulo counter with wrap/saturate, tc pulse and sticky ovf
// Optional snapshot register and ports are built when COUNTER_SNAPSHOT_EN is defined.
module counter_updown_mod #(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf,
    input  logic             ovf_clr
`ifdef COUNTER_SNAPSHOT_EN
    ,
    input  logic             snap,
    output logic [WIDTH-1:0] snap_out
`endif
);

    localparam bit SAT = (SATURATE != 0);

    logic             at_limit;
    logic             term_event;
    logic [WIDTH-1:0] step_val;

    // ">=" on the up side also catches out left above a lowered max_val or a large load.
    always_comb begin
        at_limit = 1'b0;
        step_val = out;
        if (up_dn) begin
            at_limit = (out >= max_val);
            if (at_limit) begin
                step_val = SAT ? out : '0;
            end else begin
                step_val = out + WIDTH'(1);
            end
        end else begin
            at_limit = (out == '0);
            if (at_limit) begin
                step_val = SAT ? out : max_val;
            end else begin
                step_val = out - WIDTH'(1);
            end
        end
    end

    assign term_event = en && !clr && !load && at_limit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= '0;
            tc  <= 1'b0;
        end else if (clr) begin
            out <= '0;
            tc  <= 1'b0;
        end else if (load) begin
            out <= load_val;
            tc  <= 1'b0;
        end else if (en) begin
            out <= step_val;
            tc  <= at_limit;
        end else begin
            tc  <= 1'b0;
        end
    end

    // Set takes precedence over ovf_clr on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (term_event) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

`ifdef COUNTER_SNAPSHOT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_out <= '0;
        end else if (snap) begin
            snap_out <= out;
        end
    end
`endif

endmodule

// File: tb/tb_counter_updown_mod.sv
// tb/tb_counter_updown_mod.sv - directed self-checking bench for counter_updown_mod (wrap and saturate builds)
module tb_counter_updown_mod;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         clr = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         en = 1'b0;
    logic         up_dn = 1'b1;
    logic [W-1:0] max_val = 8'd9;
    logic         ovf_clr = 1'b0;

    logic [W-1:0] w_out, s_out;
    logic         w_tc, s_tc, w_ovf, s_ovf;
`ifdef COUNTER_SNAPSHOT_EN
    logic         snap = 1'b0;
    logic [W-1:0] w_snap_out, s_snap_out;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    counter_updown_mod #(.WIDTH(W), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .max_val(max_val),
        .out(w_out), .tc(w_tc), .ovf(w_ovf), .ovf_clr(ovf_clr)
`ifdef COUNTER_SNAPSHOT_EN
        , .snap(snap), .snap_out(w_snap_out)
`endif
    );

    counter_updown_mod #(.WIDTH(W), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .max_val(max_val),
        .out(s_out), .tc(s_tc), .ovf(s_ovf), .ovf_clr(ovf_clr)
`ifdef COUNTER_SNAPSHOT_EN
        , .snap(snap), .snap_out(s_snap_out)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_w(input string tag, input int o, input int t, input int v);
        chk({tag, " w.out"}, 32'(w_out), 32'(o));
        chk({tag, " w.tc"}, 32'(w_tc), 32'(t));
        chk({tag, " w.ovf"}, 32'(w_ovf), 32'(v));
    endtask

    task automatic chk_s(input string tag, input int o, input int t, input int v);
        chk({tag, " s.out"}, 32'(s_out), 32'(o));
        chk({tag, " s.tc"}, 32'(s_tc), 32'(t));
        chk({tag, " s.ovf"}, 32'(s_ovf), 32'(v));
    endtask

    initial begin
        #3;
        chk_w("reset", 0, 0, 0);
        chk_s("reset", 0, 0, 0);
        step();
        reset = 1'b0;

        // count to 5, then async reset between edges
        en = 1'b1; up_dn = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk_w($sformatf("pre_rst up%0d", k), k, 0, 0);
        end
        reset = 1'b1;
        #2;
        chk_w("async_rst", 0, 0, 0);
        step();
        chk_w("rst_held", 0, 0, 0);
        reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk_w($sformatf("post_rst up%0d", k), k, 0, 0);
        end

        // up wrap vs saturate with max_val=9
        en = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0; en = 1'b1;
        chk_w("clr", 0, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk_w($sformatf("upwrap%0d", k), k % 10, (k == 10) ? 1 : 0, (k >= 10) ? 1 : 0);
            chk_s($sformatf("upsat%0d", k), (k < 9) ? k : 9, (k >= 10) ? 1 : 0, (k >= 10) ? 1 : 0);
        end

        // down from 1
        en = 1'b0; load = 1'b1; load_val = 8'd1;
        step();
        load = 1'b0; en = 1'b1; up_dn = 1'b0;
        chk_w("load1", 1, 0, 1);
        step();
        chk_w("dn1", 0, 0, 1);
        chk_s("dn1", 0, 0, 1);
        step();
        chk_w("dn2", 9, 1, 1);
        chk_s("dn2", 0, 1, 1);
        step();
        chk_w("dn3", 8, 0, 1);
        chk_s("dn3", 0, 1, 1);

        // ovf_clr against a same-edge terminal event
        en = 1'b0; load = 1'b1; load_val = 8'd0;
        step();
        load = 1'b0; en = 1'b1; ovf_clr = 1'b1;
        step();
        chk_w("ovf_set_wins", 9, 1, 1);
        chk_s("ovf_set_wins", 0, 1, 1);
        en = 1'b0;
        step();
        ovf_clr = 1'b0;
        chk_w("ovf_clr", 9, 0, 0);
        chk_s("ovf_clr", 0, 0, 0);

        // priority clr > load > en
        load = 1'b1; load_val = 8'd7;
        step();
        chk_w("load7", 7, 0, 0);
        clr = 1'b1; load = 1'b1; load_val = 8'd50; en = 1'b1; up_dn = 1'b1;
        step();
        chk_w("clr_wins", 0, 0, 0);
        clr = 1'b0; load_val = 8'd200;
        step();
        chk_w("load200", 200, 0, 0);
        chk_s("load200", 200, 0, 0);
        load = 1'b0;
        step();
        chk_w("above_max", 0, 1, 1);
        chk_s("above_max", 200, 1, 1);

        // max_val = 0
        max_val = 8'd0; en = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0; en = 1'b1; ovf_clr = 1'b1;
        step();
        chk_w("max0 up", 0, 1, 1);
        chk_s("max0 up", 0, 1, 1);
        ovf_clr = 1'b0; up_dn = 1'b0;
        step();
        chk_w("max0 dn", 0, 1, 1);
        chk_s("max0 dn", 0, 1, 1);

        // hold with en=0
        max_val = 8'd9; load = 1'b1; load_val = 8'd3;
        step();
        load = 1'b0; en = 1'b0;
        step();
        chk_w("hold", 3, 0, 1);
        step();
        chk_w("hold2", 3, 0, 1);

`ifdef COUNTER_SNAPSHOT_EN
        load = 1'b1; load_val = 8'd4;
        step();
        load = 1'b0; en = 1'b1; up_dn = 1'b1; snap = 1'b1;
        step();
        chk("snap out", 32'(w_out), 32'd5);
        chk("snap_out", 32'(w_snap_out), 32'd4);
        snap = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("snap hold%0d", k), 32'(w_snap_out), 32'd4);
        end
        en = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule
